time_counter: RTL and testbench

- Consumer of the clock divider's square-wave outputs. Samples the 1 Hz square wave on the 50 MHz system clock and turns each rising edge into a one-cycle enable; never uses it as a clock.
- Keeps HH:MM:SS time of day in packed BCD and supports a manual set mode driven by debounced keys.
- Feeds the display scanner and alarm logic downstream.

---
 rtl/time_counter.sv | 135 +++++++++++++
 tb/tb_time_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// ============================================================================
// Module   : time_counter
// Purpose  : HH:MM:SS BCD time of day advanced by 1 Hz tick edges, with
//            manual set mode. Optional hourly chime: TIME_COUNTER_CHIME_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module time_counter #(
  parameter int MAX_HOUR  = 23,
  parameter int INIT_HOUR = 0,
  parameter int INIT_MIN  = 0
`ifdef TIME_COUNTER_CHIME_EN
  ,
  parameter int CHIME_SECS = 5
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1HZ_in,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       sec_tick,
  output logic       hour_chime
);

  localparam logic [7:0] C_MAX_HOUR_BCD  = {4'(MAX_HOUR / 10), 4'(MAX_HOUR % 10)};
  localparam logic [7:0] C_INIT_HOUR_BCD = {4'(INIT_HOUR / 10), 4'(INIT_HOUR % 10)};
  localparam logic [7:0] C_INIT_MIN_BCD  = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10)};

  logic       r_prev_1hz;
  logic       r_prev_inc;
  logic       w_tick_edge;
  logic       w_inc_edge;
  logic       w_count;
  logic       w_set_inc;
  logic [7:0] w_sec_nxt;
  logic [7:0] w_min_nxt;
  logic [7:0] w_hour_nxt;

  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_tick_edge = clk_1HZ_in & ~r_prev_1hz;
  assign w_inc_edge  = set_inc & ~r_prev_inc;
  assign w_count     = w_tick_edge & ~set_en;
  assign w_set_inc   = w_inc_edge & set_en;

  // Counting carries across fields; set-mode increments wrap within one field.
  always_comb begin
    w_sec_nxt  = sec_bcd;
    w_min_nxt  = min_bcd;
    w_hour_nxt = hour_bcd;
    if (w_count) begin
      w_sec_nxt = inc_bcd(sec_bcd, 8'h59);
      if (sec_bcd == 8'h59) begin
        w_min_nxt = inc_bcd(min_bcd, 8'h59);
        if (min_bcd == 8'h59)
          w_hour_nxt = inc_bcd(hour_bcd, C_MAX_HOUR_BCD);
      end
    end else if (w_set_inc) begin
      case (set_sel)
        2'd0:    w_sec_nxt  = inc_bcd(sec_bcd, 8'h59);
        2'd1:    w_min_nxt  = inc_bcd(min_bcd, 8'h59);
        2'd2:    w_hour_nxt = inc_bcd(hour_bcd, C_MAX_HOUR_BCD);
        default: ;
      endcase
    end
  end

  // History registers reset high so an input already high at release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_1hz <= 1'b1;
      r_prev_inc <= 1'b1;
      sec_bcd    <= 8'h00;
      min_bcd    <= C_INIT_MIN_BCD;
      hour_bcd   <= C_INIT_HOUR_BCD;
      sec_tick   <= 1'b0;
    end else begin
      r_prev_1hz <= clk_1HZ_in;
      r_prev_inc <= set_inc;
      sec_bcd    <= w_sec_nxt;
      min_bcd    <= w_min_nxt;
      hour_bcd   <= w_hour_nxt;
      sec_tick   <= w_count;
    end
  end

`ifdef TIME_COUNTER_CHIME_EN
  logic       r_chime;
  logic [7:0] r_chime_cnt;
  logic       w_rollover;

  assign w_rollover = w_count & (sec_bcd == 8'h59) & (min_bcd == 8'h59);

  // Counter holds the number of further ticks the chime survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chime     <= 1'b0;
      r_chime_cnt <= 8'd0;
    end else if (w_rollover) begin
      r_chime     <= 1'b1;
      r_chime_cnt <= 8'(CHIME_SECS);
    end else if (set_en) begin
      r_chime     <= 1'b0;
      r_chime_cnt <= 8'd0;
    end else if (w_count && r_chime) begin
      if (r_chime_cnt <= 8'd1) begin
        r_chime     <= 1'b0;
        r_chime_cnt <= 8'd0;
      end else begin
        r_chime_cnt <= r_chime_cnt - 8'd1;
      end
    end
  end

  assign hour_chime = r_chime;
`else
  assign hour_chime = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_time_counter.sv
// Testbench for time_counter: two instances (MAX_HOUR 23 and 11) share random
// and directed stimulus; a queue-based scoreboard checks every cycle.
`default_nettype none

module tb_time_counter;

  logic       clk = 1'b0;
  logic       rst_n, clk_1hz, set_en, set_inc;
  logic [1:0] set_sel;
  logic [7:0] sec0, min0, hour0, sec1, min1, hour1;
  logic       tick0, tick1, chime0, chime1;

  always #5 clk = ~clk;

`ifdef TIME_COUNTER_CHIME_EN
  localparam bit CHIME_ON = 1'b1;
`else
  localparam bit CHIME_ON = 1'b0;
`endif
  localparam int CHIME_SECS = 5;

  time_counter #(.MAX_HOUR(23), .INIT_HOUR(12), .INIT_MIN(34)) dut0 (
    .clk(clk), .rst_n(rst_n), .clk_1HZ_in(clk_1hz), .set_en(set_en),
    .set_sel(set_sel), .set_inc(set_inc), .sec_bcd(sec0), .min_bcd(min0),
    .hour_bcd(hour0), .sec_tick(tick0), .hour_chime(chime0));

  time_counter #(.MAX_HOUR(11), .INIT_HOUR(11), .INIT_MIN(59)) dut1 (
    .clk(clk), .rst_n(rst_n), .clk_1HZ_in(clk_1hz), .set_en(set_en),
    .set_sel(set_sel), .set_inc(set_inc), .sec_bcd(sec1), .min_bcd(min1),
    .hour_bcd(hour1), .sec_tick(tick1), .hour_chime(chime1));

  typedef struct packed {
    logic [7:0] h0, m0, s0; logic t0, c0;
    logic [7:0] h1, m1, s1; logic t1, c1;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: integer time fields, one set per instance.
  int maxh[2] = '{23, 11};
  int ih[2]   = '{12, 11};
  int im[2]   = '{34, 59};
  int mh[2], mm[2], ms[2], mt[2], mc[2], mcnt[2];
  bit prev1 = 1'b1, previnc = 1'b1;

  bit cur_r, cur_1hz, cur_en, cur_inc;
  bit [1:0] cur_sel;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_step();
    bit te, ie, tk, roll;
    te = cur_1hz && !prev1;
    ie = cur_inc && !previnc;
    for (int k = 0; k < 2; k++) begin
      if (!cur_r) begin
        ms[k] = 0; mm[k] = im[k]; mh[k] = ih[k]; mt[k] = 0; mc[k] = 0; mcnt[k] = 0;
      end else begin
        tk = te && !cur_en;
        roll = 1'b0;
        mt[k] = tk ? 1 : 0;
        if (tk) begin
          ms[k]++;
          if (ms[k] == 60) begin
            ms[k] = 0;
            mm[k]++;
            if (mm[k] == 60) begin
              mm[k] = 0;
              roll = 1'b1;
              mh[k] = (mh[k] == maxh[k]) ? 0 : mh[k] + 1;
            end
          end
        end else if (cur_en && ie) begin
          case (cur_sel)
            2'd0: ms[k] = (ms[k] + 1) % 60;
            2'd1: mm[k] = (mm[k] + 1) % 60;
            2'd2: mh[k] = (mh[k] == maxh[k]) ? 0 : mh[k] + 1;
            default: ;
          endcase
        end
        if (CHIME_ON) begin
          if (roll) begin
            mc[k] = 1; mcnt[k] = CHIME_SECS;
          end else if (cur_en) begin
            mc[k] = 0; mcnt[k] = 0;
          end else if (tk && mc[k] == 1) begin
            if (mcnt[k] <= 1) mc[k] = 0;
            else mcnt[k]--;
          end
        end
      end
    end
    prev1   = cur_r ? cur_1hz : 1'b1;
    previnc = cur_r ? cur_inc : 1'b1;
  endtask

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    rst_n = cur_r; clk_1hz = cur_1hz; set_en = cur_en; set_sel = cur_sel; set_inc = cur_inc;
    model_step();
    e.h0 = bcd(mh[0]); e.m0 = bcd(mm[0]); e.s0 = bcd(ms[0]);
    e.t0 = mt[0][0];   e.c0 = mc[0][0];
    e.h1 = bcd(mh[1]); e.m1 = bcd(mm[1]); e.s1 = bcd(ms[1]);
    e.t1 = mt[1][0];   e.c1 = mc[1][0];
    q.push_back(e);
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_1hz();
    cur_1hz = 1'b0; cyc();
    cur_1hz = 1'b1; cyc();
  endtask

  task automatic pulse_inc();
    cur_inc = 1'b0; cyc();
    cur_inc = 1'b1; cyc();
  endtask

  task automatic set_to(input int k, input int h, input int m, input int s);
    cur_en = 1'b1;
    cur_sel = 2'd2; for (int i = 0; i < 30 && mh[k] != h; i++) pulse_inc();
    cur_sel = 2'd1; for (int i = 0; i < 70 && mm[k] != m; i++) pulse_inc();
    cur_sel = 2'd0; for (int i = 0; i < 70 && ms[k] != s; i++) pulse_inc();
    cur_en = 1'b0; cur_sel = 2'd3; cyc();
  endtask

  // Monitor: every cycle the DUTs present a new state, compare with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hms0",   {hour0, min0, sec0}, {e.h0, e.m0, e.s0});
        chk("tick0",  {23'd0, tick0},  {23'd0, e.t0});
        chk("chime0", {23'd0, chime0}, {23'd0, e.c0});
        chk("hms1",   {hour1, min1, sec1}, {e.h1, e.m1, e.s1});
        chk("tick1",  {23'd0, tick1},  {23'd0, e.t1});
        chk("chime1", {23'd0, chime1}, {23'd0, e.c1});
      end
    end
  end

  initial begin
    cur_r = 1'b0; cur_1hz = 1'b1; cur_en = 1'b0; cur_sel = 2'd3; cur_inc = 1'b1;
    rst_n = 1'b0; clk_1hz = 1'b1; set_en = 1'b0; set_sel = 2'd3; set_inc = 1'b1;
    repeat (3) cyc();
    post();
    chk("reset_hms0", {hour0, min0, sec0}, 24'h123400);
    chk("reset_hms1", {hour1, min1, sec1}, 24'h115900);

    // Release with the 1 Hz input already high: no tick may appear.
    cur_r = 1'b1;
    repeat (6) cyc();
    post();
    chk("no_tick_at_release", {hour0, min0, sec0, tick0}, {8'h12, 8'h34, 8'h00, 1'b0});
    pulse_1hz();
    post();
    chk("first_tick", {hour0, min0, sec0}, 24'h123401);

    set_to(0, 0, 0, 58);
    pulse_1hz(); post();
    chk("sec_59", {hour0, min0, sec0}, 24'h000059);
    pulse_1hz(); post();
    chk("min_carry", {hour0, min0, sec0}, 24'h000100);

    set_to(0, 23, 59, 59);
    pulse_1hz(); post();
    chk("wrap_23", {hour0, min0, sec0}, 24'h000000);
    set_to(1, 11, 59, 59);
    pulse_1hz(); post();
    chk("wrap_11", {hour1, min1, sec1}, 24'h000000);

    set_to(0, 10, 59, 30);
    cur_en = 1'b1; cur_sel = 2'd1;
    pulse_inc(); post();
    chk("set_min_nocarry", {hour0, min0, sec0}, 24'h100030);
    repeat (10) pulse_1hz();
    post();
    chk("frozen_secs", {hour0, min0, sec0}, 24'h100030);

    cur_sel = 2'd3;
    repeat (3) pulse_inc();
    cur_1hz = 1'b0; cyc();
    cur_1hz = 1'b1; cyc();
    cur_en = 1'b0; cyc();
    post();
    chk("tick_dropped", {hour0, min0, sec0}, 24'h100030);
    pulse_1hz(); post();
    chk("tick_resumes", {hour0, min0, sec0}, 24'h100031);

    if (CHIME_ON) begin
      set_to(0, 5, 59, 59);
      pulse_1hz(); post();
      chk("chime_on", {hour0, min0, sec0, chime0}, {8'h06, 8'h00, 8'h00, 1'b1});
      repeat (4) pulse_1hz();
      post();
      chk("chime_held", {hour0, min0, sec0, chime0}, {8'h06, 8'h00, 8'h04, 1'b1});
      pulse_1hz(); post();
      chk("chime_off", {hour0, min0, sec0, chime0}, {8'h06, 8'h00, 8'h05, 1'b0});
      set_to(0, 5, 59, 59);
      pulse_1hz(); post();
      cur_en = 1'b1; cyc(); post();
      chk("chime_set_clear", {23'd0, chime0}, 24'd0);
      cur_en = 1'b0;
    end

    // Randomized phase: square-wave jitter, set-mode bursts, key bounces, resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(2) == 0) cur_1hz = ~cur_1hz;
      if ($urandom_range(24) == 0) cur_en = ~cur_en;
      if ($urandom_range(9) == 0) cur_sel = 2'($urandom_range(3));
      if ($urandom_range(2) == 0) cur_inc = ~cur_inc;
      cur_r = ($urandom_range(799) != 0);
      cyc();
    end
    cur_r = 1'b1;
    repeat (3) cyc();
    post();
    post();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
